// File: rtl/mem_rw_pkg.sv
// Shared definitions for the S-memory reader/writer pair: default geometry,
// read-side FSM state encoding and RAM timing constants.
package mem_rw_pkg;

  // Default memory geometry (256 x 8), shared with memory_write.
  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 8;
  localparam int MEM_DEPTH  = 1 << ADDR_W;

  // The RAM returns mem_q exactly this many cycles after mem_rden.
  localparam int RD_LATENCY = 1;

  // Reader FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

endpackage : mem_rw_pkg

// File: rtl/rd_buffer2.sv
// Two-entry FIFO that absorbs RAM read returns so a stalled consumer never
// loses a word. Push and pop in the same cycle leave the count unchanged.
// A push into a full buffer (without a simultaneous pop) and a pop from an
// empty buffer are both ignored; the caller's credit check prevents them.
module rd_buffer2 #(
  parameter int DATA_W = mem_rw_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [1:0]        o_count,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_head
);

  logic [DATA_W-1:0] r_entry [2];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_count;

  logic              w_pop_ok;
  logic              w_push_ok;

  assign w_pop_ok  = i_pop && (r_count != 2'd0);
  assign w_push_ok = i_push && ((r_count != 2'd2) || w_pop_ok);

  // Storage and pointer updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_entry[i] <= '0;
      end
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_entry[r_wr_ptr] <= i_push_data;
        r_wr_ptr          <= ~r_wr_ptr;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

  // Occupancy count: simultaneous push and pop cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_valid = (r_count != 2'd0);
  assign o_head  = r_entry[r_rd_ptr];

endmodule : rd_buffer2

// File: rtl/memory_read.sv
// Streaming reader for the 256x8 S-memory. On an accepted start it reads
// `length` consecutive bytes from `base_addr` (wrapping at the top of memory),
// hides the RAM's 1-cycle read latency behind a 2-entry buffer and presents
// the bytes in address order on a valid/ready stream.
//
// Handshake: a word moves when out_valid && out_ready on a rising edge;
// out_valid never drops and out_data never changes while out_valid is high
// and out_ready is low.
module memory_read #(
  parameter int ADDR_W = mem_rw_pkg::ADDR_W,
  parameter int DATA_W = mem_rw_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rden,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              finish,
  output logic [1:0]        dbg_state
);

  import mem_rw_pkg::*;

  localparam logic [ADDR_W:0] CNT_ZERO = '0;
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  rd_state_t         r_state;
  rd_state_t         w_next_state;

  logic [ADDR_W-1:0] r_next_addr;
  logic [ADDR_W:0]   r_rem_issue;
  logic [ADDR_W:0]   r_rem_accept;
  logic              r_inflight;

  logic              w_start_ok;
  logic              w_issue;
  logic              w_pop;
  logic [1:0]        w_count;
  logic [2:0]        w_occupancy;
  logic              w_buf_valid;
  logic [DATA_W-1:0] w_head;

  assign w_start_ok  = (r_state == IDLE) && start;
  assign w_pop       = w_buf_valid && out_ready;

  // Words already buffered plus the one in flight, less the one leaving now.
  // A new read may only be issued if its return is guaranteed a slot.
  assign w_occupancy = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};

  // Return buffer; the RAM word is captured the cycle after the read issue.
  rd_buffer2 #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_inflight),
    .i_push_data (mem_q),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_valid     (w_buf_valid),
    .o_head      (w_head)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and read-issue decision.
  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = (length == CNT_ZERO) ? DONE : READ;
        end
      end
      READ: begin
        if (w_occupancy < 3'd2) begin
          w_issue = 1'b1;
        end
        if (w_issue && (r_rem_issue == CNT_ONE)) begin
          w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        // Leave on the same edge that transfers the final word.
        if ((r_rem_accept == CNT_ZERO) ||
            ((r_rem_accept == CNT_ONE) && w_pop)) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Address generator and issue counter; start is only honoured in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_next_addr <= '0;
      r_rem_issue <= '0;
    end else if (w_start_ok) begin
      r_next_addr <= base_addr;
      r_rem_issue <= length;
    end else if (w_issue) begin
      r_next_addr <= r_next_addr + 1'b1;
      r_rem_issue <= r_rem_issue - 1'b1;
    end
  end

  // Count of words still owed to the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem_accept <= '0;
    end else if (w_start_ok) begin
      r_rem_accept <= length;
    end else if (w_pop && (r_rem_accept != CNT_ZERO)) begin
      r_rem_accept <= r_rem_accept - 1'b1;
    end
  end

  // Marks a read whose data appears on mem_q next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
    end
  end

  assign mem_addr  = r_next_addr;
  assign mem_rden  = w_issue;
  assign out_valid = w_buf_valid;
  assign out_data  = w_head;
  assign busy      = (r_state != IDLE);
  assign finish    = (r_state == DONE);
  assign dbg_state = r_state;

endmodule : memory_read

// File: tb/tb_memory_read.sv
// Directed bench for memory_read with a behavioural 256x8 RAM (mem[i] = i).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// Observation index k counts falling edges after the accepted start edge T,
// so k reflects the state after rising edge T+k-1.
module tb_memory_read;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              start     = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   length    = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rden;
  logic [DATA_W-1:0] mem_q     = '0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              busy;
  logic              finish;
  logic [1:0]        dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DATA_W-1:0] mem [256];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] obs_data_q [$];
  logic [ADDR_W-1:0] obs_addr_q [$];

  int first_valid_k, finish_k, finish_cnt, busy_low_k, busy_cycles;
  int stall_viol, last_xfer_k, words;
  bit timed_out;

  memory_read #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .mem_addr  (mem_addr),
    .mem_rden  (mem_rden),
    .mem_q     (mem_q),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .finish    (finish),
    .dbg_state (dbg_state)
  );

  // Clock / RAM model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rden) mem_q <= mem[mem_addr];
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  // Driver: one-cycle start pulse.
  task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l);
    @(negedge clk);
    start = 1'b1; base_addr = b; length = l; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Driver/monitor: runs the stream, records what the DUT does. No checking.
  task automatic run_stream(input int max_cyc, input bit rnd_ready,
                            input int restart_k, input int stop_words);
    logic [15:0]       pat;
    logic              prev_stall;
    logic [DATA_W-1:0] prev_data;
    pat = 16'b1101_1000_1011_0010;
    prev_stall = 1'b0; prev_data = '0;
    first_valid_k = -1; finish_k = -1; finish_cnt = 0; busy_low_k = -1;
    busy_cycles = 0; stall_viol = 0; last_xfer_k = -1; words = 0; timed_out = 0;
    obs_data_q.delete(); obs_addr_q.delete();
    for (int k = 1; k <= max_cyc; k++) begin
      out_ready = rnd_ready ? pat[k % 16] : 1'b1;
      if (k == restart_k) begin
        start = 1'b1; base_addr = 8'h80; length = 9'd5;
      end else begin
        start = 1'b0;
      end
      #1;
      if (prev_stall && (!out_valid || (out_data !== prev_data))) stall_viol++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (busy) busy_cycles++;
      if (mem_rden) obs_addr_q.push_back(mem_addr);
      if (out_valid && (first_valid_k < 0)) first_valid_k = k;
      if (out_valid && out_ready) begin
        obs_data_q.push_back(out_data); words++; last_xfer_k = k;
      end
      if (finish) begin
        finish_cnt++;
        if (finish_k < 0) finish_k = k;
      end
      if (!busy && (finish_k >= 0)) begin
        busy_low_k = k;
        return;
      end
      if ((stop_words > 0) && (words == stop_words)) return;
      @(negedge clk);
    end
    timed_out = 1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mem_addr, mem_rden, out_valid, out_data, busy, finish} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got addr=%h rden=%b vld=%b data=%h busy=%b fin=%b, want all 0",
               mem_addr, mem_rden, out_valid, out_data, busy, finish);
    end
    n_cmp++;
    if (dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_256;
    pulse_start(8'h00, 9'd256);
    run_stream(400, 1'b0, 0, 0);
    n_cmp++;
    if (timed_out) begin n_fail++; $display("FAIL full_timeout: got timeout want completion"); end
    for (int i = 0; i < 256; i++) exp_q.push_back(i[7:0]);
    n_cmp++;
    if (obs_data_q.size() != 256) begin
      n_fail++; $display("FAIL full_count: got %0d want 256", obs_data_q.size());
    end
    while (exp_q.size() > 0 && obs_data_q.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = obs_data_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL full_data: got %h want %h", o, e); end
    end
    exp_q.delete();
    n_cmp++;
    if (first_valid_k != 3) begin n_fail++; $display("FAIL full_first_valid: got k=%0d want 3", first_valid_k); end
    n_cmp++;
    if (last_xfer_k != 258) begin n_fail++; $display("FAIL full_last_xfer: got k=%0d want 258", last_xfer_k); end
    n_cmp++;
    if (finish_k != 259) begin n_fail++; $display("FAIL full_finish_time: got k=%0d want 259", finish_k); end
    n_cmp++;
    if (busy_low_k != 260) begin n_fail++; $display("FAIL full_busy_low: got k=%0d want 260", busy_low_k); end
    n_cmp++;
    if (finish_cnt != 1) begin n_fail++; $display("FAIL full_finish_cnt: got %0d want 1", finish_cnt); end
    n_cmp++;
    if (obs_addr_q.size() != 256) begin n_fail++; $display("FAIL full_rden_cnt: got %0d want 256", obs_addr_q.size()); end
  endtask

  task automatic test_wrap;
    logic [7:0] exp_addr [4];
    exp_addr[0] = 8'hFE; exp_addr[1] = 8'hFF; exp_addr[2] = 8'h00; exp_addr[3] = 8'h01;
    pulse_start(8'hFE, 9'd4);
    run_stream(50, 1'b0, 0, 0);
    n_cmp++;
    if (obs_addr_q.size() != 4) begin n_fail++; $display("FAIL wrap_rden_cnt: got %0d want 4", obs_addr_q.size()); end
    n_cmp++;
    if (obs_data_q.size() != 4) begin n_fail++; $display("FAIL wrap_count: got %0d want 4", obs_data_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < obs_addr_q.size()) begin
        n_cmp++;
        if (obs_addr_q[i] !== exp_addr[i]) begin
          n_fail++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, obs_addr_q[i], exp_addr[i]);
        end
      end
      if (i < obs_data_q.size()) begin
        n_cmp++;
        if (obs_data_q[i] !== exp_addr[i]) begin
          n_fail++; $display("FAIL wrap_data[%0d]: got %h want %h", i, obs_data_q[i], exp_addr[i]);
        end
      end
    end
    n_cmp++;
    if (finish_cnt != 1) begin n_fail++; $display("FAIL wrap_finish_cnt: got %0d want 1", finish_cnt); end
  endtask

  task automatic test_stall;
    pulse_start(8'h10, 9'd8);
    run_stream(200, 1'b1, 0, 0);
    n_cmp++;
    if (timed_out) begin n_fail++; $display("FAIL stall_timeout: got timeout want completion"); end
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h10 + i[7:0]);
    n_cmp++;
    if (obs_data_q.size() != 8) begin n_fail++; $display("FAIL stall_count: got %0d want 8", obs_data_q.size()); end
    while (exp_q.size() > 0 && obs_data_q.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = obs_data_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL stall_data: got %h want %h", o, e); end
    end
    exp_q.delete();
    n_cmp++;
    if (stall_viol != 0) begin n_fail++; $display("FAIL stall_stability: got %0d unstable cycles want 0", stall_viol); end
    n_cmp++;
    if (obs_addr_q.size() != 8) begin n_fail++; $display("FAIL stall_rden_cnt: got %0d want 8", obs_addr_q.size()); end
    n_cmp++;
    if (finish_cnt != 1) begin n_fail++; $display("FAIL stall_finish_cnt: got %0d want 1", finish_cnt); end
  endtask

  task automatic test_zero_len;
    pulse_start(8'h33, 9'd0);
    run_stream(20, 1'b0, 0, 0);
    n_cmp++;
    if (obs_addr_q.size() != 0) begin n_fail++; $display("FAIL zero_rden: got %0d reads want 0", obs_addr_q.size()); end
    n_cmp++;
    if (first_valid_k != -1) begin n_fail++; $display("FAIL zero_valid: got valid at k=%0d want none", first_valid_k); end
    n_cmp++;
    if (finish_k != 1) begin n_fail++; $display("FAIL zero_finish_time: got k=%0d want 1", finish_k); end
    n_cmp++;
    if (busy_cycles != 1) begin n_fail++; $display("FAIL zero_busy_cycles: got %0d want 1", busy_cycles); end
    n_cmp++;
    if (busy_low_k != 2) begin n_fail++; $display("FAIL zero_busy_low: got k=%0d want 2", busy_low_k); end
  endtask

  task automatic test_restart_ignored;
    pulse_start(8'h30, 9'd20);
    run_stream(100, 1'b0, 6, 0);
    for (int i = 0; i < 20; i++) exp_q.push_back(8'h30 + i[7:0]);
    n_cmp++;
    if (obs_data_q.size() != 20) begin n_fail++; $display("FAIL restart_count: got %0d want 20", obs_data_q.size()); end
    while (exp_q.size() > 0 && obs_data_q.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = obs_data_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL restart_data: got %h want %h", o, e); end
    end
    exp_q.delete();
    n_cmp++;
    if (finish_cnt != 1) begin n_fail++; $display("FAIL restart_finish_cnt: got %0d want 1", finish_cnt); end
    n_cmp++;
    if (obs_addr_q.size() != 20) begin n_fail++; $display("FAIL restart_rden_cnt: got %0d want 20", obs_addr_q.size()); end
  endtask

  task automatic test_reset_mid;
    int fin_seen;
    pulse_start(8'h20, 9'd20);
    run_stream(100, 1'b0, 0, 5);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mem_addr, mem_rden, out_valid, out_data, busy, finish} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got addr=%h rden=%b vld=%b data=%h busy=%b fin=%b, want all 0",
               mem_addr, mem_rden, out_valid, out_data, busy, finish);
    end
    fin_seen = 0;
    repeat (3) begin
      @(negedge clk); #1;
      if (finish) fin_seen++;
    end
    n_cmp++;
    if (fin_seen != 0) begin n_fail++; $display("FAIL midreset_finish: got %0d pulses want 0", fin_seen); end
    rst_n = 1'b1;
    pulse_start(8'h40, 9'd3);
    run_stream(50, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) exp_q.push_back(8'h40 + i[7:0]);
    n_cmp++;
    if (obs_data_q.size() != 3) begin n_fail++; $display("FAIL after_reset_count: got %0d want 3", obs_data_q.size()); end
    while (exp_q.size() > 0 && obs_data_q.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = obs_data_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL after_reset_data: got %h want %h", o, e); end
    end
    exp_q.delete();
    n_cmp++;
    if (finish_cnt != 1) begin n_fail++; $display("FAIL after_reset_finish_cnt: got %0d want 1", finish_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = i[7:0];
    test_reset();
    test_full_256();
    test_wrap();
    test_stall();
    test_zero_len();
    test_restart_ignored();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_memory_read
